predecode_fetch_queue: RTL and testbench

- WIDTH-wide successor to the single-instruction branch predecoder.
- Each cycle it predecodes up to WIDTH fetched Alpha instructions and classifies each as cond branch, uncond branch, call, return or illegal branch.
- It drops lanes that follow an unconditional control transfer in the same bundle, and buffers the survivors in an in-order circular queue of DEPTH entries.
- Sits between I-cache fetch and decode; its classification bits feed the BTB, direction predictor and RAS.

---
 rtl/predecode_fetch_queue.sv | 162 ++++++++++++++++
 tb/tb_predecode_fetch_queue.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/predecode_fetch_queue.sv
// Multi-lane Alpha branch predecoder feeding an in-order fetch queue.
// Classifies control transfers and drops lanes shadowed by an uncond jump.
module predecode_fetch_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int PC_W  = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_valid,
  input  logic [WIDTH*32-1:0]          in_inst,
  input  logic [WIDTH*PC_W-1:0]        in_pc,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_valid,
  output logic [WIDTH*32-1:0]          out_inst,
  output logic [WIDTH*PC_W-1:0]        out_pc,
  output logic [WIDTH-1:0]             out_is_br,
  output logic [WIDTH-1:0]             out_uncond,
  output logic [WIDTH-1:0]             out_is_call,
  output logic [WIDTH-1:0]             out_is_ret,
  output logic [WIDTH-1:0]             out_illegal,
  input  logic [$clog2(WIDTH+1)-1:0]   out_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(WIDTH+1);

  typedef struct packed {
    logic br;
    logic uncond;
    logic call;
    logic ret;
    logic ill;
  } flags_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    flags_t          f;
  } entry_t;

  function automatic flags_t predecode(
    input logic [5:0] op,
    input logic [1:0] sel
  );
    flags_t f;
    f = '0;
    unique case (1'b1)
      (op[5:3] == 3'b110) && (op[1:0] == 2'b00): begin
        f.uncond = 1'b1;
        f.call   = op[2];
      end
      (op[5:3] == 3'b110) && (op[1:0] != 2'b00):
        f.ill = 1'b1;
      (op[5:3] == 3'b111):
        f.br = 1'b1;
      (op == 6'h1A): begin
        // JMP/JSR/RET/JSR_CO: hint bits map straight onto call/ret
        f.uncond = 1'b1;
        f.call   = sel[0];
        f.ret    = sel[1];
      end
      (op == 6'h18) || (op == 6'h1C):
        f.ill = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  entry_t         mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;

  flags_t         lane_f [WIDTH];
  logic [TW-1:0]  pos    [WIDTH];
  logic [WIDTH-1:0] keep;
  logic [TW-1:0]  n_kept;
  logic           blocked;

  logic [CW-1:0]  take_ext;
  logic [CW-1:0]  taken;
  logic [CW-1:0]  written;

  always_comb begin
    keep    = '0;
    n_kept  = '0;
    blocked = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_f[i] = predecode(in_inst[32*i+26 +: 6],
                            in_inst[32*i+14 +: 2]);
      pos[i] = n_kept;
      if (in_valid[i] && !blocked) begin
        keep[i] = 1'b1;
        n_kept  = n_kept + TW'(1);
        blocked = lane_f[i].uncond;
      end
    end
  end

  assign in_ready = (count <= CW'(DEPTH - WIDTH));
  assign take_ext = CW'(out_take);
  assign taken    = (take_ext > count) ? count : take_ext;
  assign written  = in_ready ? CW'(n_kept) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(taken);
      tail  <= tail + PW'(written);
      count <= count + written - taken;
    end
  end

  // Payload storage is not reset; out_* masking hides stale entries.
  always_ff @(posedge clock) begin
    if (in_ready && !flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (keep[i]) begin
          mem[tail + PW'(pos[i])] <= {
            in_inst[32*i +: 32],
            in_pc[PC_W*i +: PC_W],
            lane_f[i]
          };
        end
      end
    end
  end

  always_comb begin
    entry_t e;
    out_valid   = '0;
    out_inst    = '0;
    out_pc      = '0;
    out_is_br   = '0;
    out_uncond  = '0;
    out_is_call = '0;
    out_is_ret  = '0;
    out_illegal = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i] = (count > CW'(i));
      e = out_valid[i] ? mem[head + PW'(i)] : '0;
      out_inst[32*i +: 32]     = e.inst;
      out_pc[PC_W*i +: PC_W]   = e.pc;
      out_is_br[i]   = e.f.br;
      out_uncond[i]  = e.f.uncond;
      out_is_call[i] = e.f.call;
      out_is_ret[i]  = e.f.ret;
      out_illegal[i] = e.f.ill;
    end
  end

endmodule

// File: tb/tb_predecode_fetch_queue.sv
// Scoreboard bench for predecode_fetch_queue (WIDTH=2, DEPTH=8).
// Expected entries are queued at drive time and compared at dequeue.
module tb_predecode_fetch_queue;

  logic          clock;
  logic          reset;
  logic          flush;
  logic [1:0]    in_valid;
  logic [63:0]   in_inst;
  logic [127:0]  in_pc;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [63:0]   out_inst;
  logic [127:0]  out_pc;
  logic [1:0]    out_is_br;
  logic [1:0]    out_uncond;
  logic [1:0]    out_is_call;
  logic [1:0]    out_is_ret;
  logic [1:0]    out_illegal;
  logic [1:0]    out_take;
  logic [3:0]    count;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [4:0]  f;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  predecode_fetch_queue #(.WIDTH(2), .DEPTH(8), .PC_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_is_br   (out_is_br),
    .out_uncond  (out_uncond),
    .out_is_call (out_is_call),
    .out_is_ret  (out_is_ret),
    .out_illegal (out_illegal),
    .out_take    (out_take),
    .count       (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [25:0] lo);
    return {op, lo};
  endfunction

  // {br, uncond, call, ret, illegal}
  function automatic logic [4:0] ref_flags(input logic [31:0] inst);
    case (inst[31:26])
      6'h30: return 5'b01000;
      6'h34: return 5'b01100;
      6'h31, 6'h32, 6'h33,
      6'h35, 6'h36, 6'h37: return 5'b00001;
      6'h38, 6'h39, 6'h3A, 6'h3B,
      6'h3C, 6'h3D, 6'h3E, 6'h3F: return 5'b10000;
      6'h1A:
        case (inst[15:14])
          2'b00:   return 5'b01000;
          2'b01:   return 5'b01100;
          2'b10:   return 5'b01010;
          default: return 5'b01110;
        endcase
      6'h18, 6'h1C: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] obs_flags(input int i);
    return {out_is_br[i], out_uncond[i], out_is_call[i],
            out_is_ret[i], out_illegal[i]};
  endfunction

  task automatic drive(input logic [1:0] v,
                       input logic [31:0] i0, input logic [63:0] p0,
                       input logic [31:0] i1, input logic [63:0] p1,
                       input int take, input logic fl);
    logic [31:0] ins [2];
    logic [63:0] pcs [2];
    bit rdy;
    bit stop;
    int n;
    ins[0] = i0; ins[1] = i1;
    pcs[0] = p0; pcs[1] = p1;
    in_valid = v;
    in_inst  = {i1, i0};
    in_pc    = {p1, p0};
    out_take = 2'(take);
    flush    = fl;
    if (fl) begin
      sb.delete();
    end else begin
      rdy = (sb.size() <= 6);
      n = (take > sb.size()) ? sb.size() : take;
      repeat (n) void'(sb.pop_front());
      stop = 1'b0;
      if (rdy) begin
        for (int l = 0; l < 2; l++) begin
          if (v[l] && !stop) begin
            sb.push_back('{inst: ins[l], pc: pcs[l],
                           f: ref_flags(ins[l])});
            stop = ref_flags(ins[l])[3];
          end
        end
      end
    end
    @(posedge clock);
    #1;
    in_valid = '0;
    out_take = '0;
    flush    = 1'b0;
  endtask

  task automatic test_drain(input string tag);
    int  guard;
    bit  ev;
    guard = 0;
    while (sb.size() > 0 && guard < 16) begin
      checks++;
      if (count !== 4'(sb.size())) begin
        errors++;
        $display("FAIL %s_count got %0d want %0d", tag, count, sb.size());
      end
      for (int i = 0; i < 2; i++) begin
        ev = (i < sb.size());
        checks++;
        if (out_valid[i] !== ev) begin
          errors++;
          $display("FAIL %s_valid%0d got %b want %b",
                   tag, i, out_valid[i], ev);
        end
        if (ev) begin
          checks++;
          if ({out_inst[32*i +: 32], out_pc[64*i +: 64], obs_flags(i)}
              !== {sb[i].inst, sb[i].pc, sb[i].f}) begin
            errors++;
            $display("FAIL %s_lane%0d got %h/%h/%b want %h/%h/%b", tag, i,
                     out_inst[32*i +: 32], out_pc[64*i +: 64], obs_flags(i),
                     sb[i].inst, sb[i].pc, sb[i].f);
          end
        end
      end
      drive(2'b00, '0, '0, '0, '0, 2, 1'b0);
      guard++;
    end
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00 ||
        out_inst !== '0 || out_pc !== '0) begin
      errors++;
      $display("FAIL %s_empty got cnt=%0d v=%b inst=%h want 0/00/0",
               tag, count, out_valid, out_inst);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = '0;
    in_inst = '0; in_pc = '0; out_take = '0;
    #12;
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1 ||
        out_inst !== '0) begin
      errors++;
      $display("FAIL reset got cnt=%0d v=%b rdy=%b want 0/00/1",
               count, out_valid, in_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    drive(2'b11, mk(6'h10, 26'h0401), 64'h100,
                 mk(6'h39, 26'h0010), 64'h104, 0, 1'b0);
    checks++;
    if (count !== 4'd2 || out_valid !== 2'b11) begin
      errors++;
      $display("FAIL basic_count got %0d/%b want 2/11", count, out_valid);
    end
    checks++;
    if (out_is_br !== 2'b10 ||
        (out_uncond | out_is_call | out_is_ret | out_illegal) !== 2'b00) begin
      errors++;
      $display("FAIL basic_flags got br=%b u=%b c=%b r=%b i=%b want 10/0/0/0/0",
               out_is_br, out_uncond, out_is_call, out_is_ret, out_illegal);
    end
    checks++;
    if (out_pc !== {64'h104, 64'h100}) begin
      errors++;
      $display("FAIL basic_pc got %h want 104/100", out_pc);
    end
    test_drain("basic");
  endtask

  task automatic test_br_truncate();
    drive(2'b11, mk(6'h30, 26'h0), 64'h200,
                 mk(6'h10, 26'h0402), 64'h204, 0, 1'b0);
    checks++;
    if (count !== 4'd1 || out_valid !== 2'b01 || out_uncond !== 2'b01) begin
      errors++;
      $display("FAIL br_trunc got cnt=%0d v=%b u=%b want 1/01/01",
               count, out_valid, out_uncond);
    end
    checks++;
    if (out_pc[63:0] !== 64'h200) begin
      errors++;
      $display("FAIL br_pc got %h want 200", out_pc[63:0]);
    end
    test_drain("br");
  endtask

  task automatic test_jsr_co();
    drive(2'b11, mk(6'h1A, {10'h3FF, 2'b11, 14'h0}), 64'h300,
                 mk(6'h31, 26'h0), 64'h304, 0, 1'b0);
    checks++;
    if (count !== 4'd1 || out_valid !== 2'b01) begin
      errors++;
      $display("FAIL jsrco_count got %0d/%b want 1/01", count, out_valid);
    end
    checks++;
    if (obs_flags(0) !== 5'b01110) begin
      errors++;
      $display("FAIL jsrco_flags got %b want 01110", obs_flags(0));
    end
    test_drain("jsrco");
  endtask

  task automatic test_fp_bsr();
    drive(2'b11, mk(6'h31, 26'h0), 64'h400,
                 mk(6'h34, 26'h5), 64'h404, 0, 1'b0);
    checks++;
    if (count !== 4'd2 || out_illegal !== 2'b01 || out_uncond !== 2'b10 ||
        out_is_call !== 2'b10 || out_is_br !== 2'b00) begin
      errors++;
      $display("FAIL fpbsr got cnt=%0d i=%b u=%b c=%b want 2/01/10/10",
               count, out_illegal, out_uncond, out_is_call);
    end
  endtask

  task automatic test_fill_wrap();
    drive(2'b11, mk(6'h11, 26'h1), 64'h500, mk(6'h11, 26'h2), 64'h504, 0, 1'b0);
    drive(2'b11, mk(6'h11, 26'h3), 64'h508, mk(6'h11, 26'h4), 64'h50C, 0, 1'b0);
    checks++;
    if (count !== 4'd6 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill6 got %0d/%b want 6/1", count, in_ready);
    end
    drive(2'b01, mk(6'h11, 26'h5), 64'h510, '0, '0, 0, 1'b0);
    checks++;
    if (count !== 4'd7 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill7 got %0d/%b want 7/0", count, in_ready);
    end
    drive(2'b11, mk(6'h11, 26'h6), 64'h514, mk(6'h11, 26'h7), 64'h518, 0, 1'b0);
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL full_ignore got %0d want 7", count);
    end
    drive(2'b00, '0, '0, '0, '0, 2, 1'b0);
    checks++;
    if (count !== 4'd5 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL take2 got %0d/%b want 5/1", count, in_ready);
    end
    drive(2'b11, mk(6'h3B, 26'h8), 64'h520, mk(6'h12, 26'h9), 64'h524, 0, 1'b0);
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL wrap_count got %0d want 7", count);
    end
    test_drain("wrap");
  endtask

  task automatic test_back_to_back();
    // first take arrives on an empty queue and must be clamped
    drive(2'b11, mk(6'h10, 26'hA), 64'h600, mk(6'h10, 26'hB), 64'h604, 1, 1'b0);
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL b2b_clamp got %0d want 2", count);
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, mk(6'h10, 26'(k)), 64'h610 + 64'(8*k),
                   mk(6'h39, 26'(k)), 64'h614 + 64'(8*k), 1, 1'b0);
      checks++;
      if (count !== 4'(3 + k) || out_pc[63:0] !== sb[0].pc) begin
        errors++;
        $display("FAIL b2b_step%0d got %0d/%h want %0d/%h",
                 k, count, out_pc[63:0], 3 + k, sb[0].pc);
      end
    end
  endtask

  task automatic test_flush();
    drive(2'b11, mk(6'h30, 26'h0), 64'h700, mk(6'h10, 26'h0), 64'h704, 1, 1'b1);
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1 ||
        out_pc !== '0) begin
      errors++;
      $display("FAIL flush got cnt=%0d v=%b rdy=%b want 0/00/1",
               count, out_valid, in_ready);
    end
    drive(2'b11, mk(6'h1A, {10'h0, 2'b10, 14'h0}), 64'h800,
                 mk(6'h10, 26'h0), 64'h804, 0, 1'b0);
    test_drain("postflush");
  endtask

  task automatic test_async_reset();
    drive(2'b11, mk(6'h10, 26'h1), 64'h900, mk(6'h1C, 26'h1), 64'h904, 0, 1'b0);
    drive(2'b11, mk(6'h18, 26'h1), 64'h908, mk(6'h10, 26'h1), 64'h90C, 0, 1'b0);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d v=%b rdy=%b want 0/00/1",
               count, out_valid, in_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    drive(2'b11, mk(6'h1C, 26'h2), 64'hA00, mk(6'h3F, 26'h2), 64'hA04, 0, 1'b0);
    test_drain("postreset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_br_truncate();
    test_jsr_co();
    test_fp_bsr();
    test_fill_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
